// File: rtl/mc_pkg.sv
// Shared state, opcode and control-code definitions for the multicycle controller.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_MD  = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL = 4'd0,
        C_ALU = 4'd1,
        C_LW  = 4'd2,
        C_SW  = 4'd3,
        C_BEQ = 4'd4,
        C_J   = 4'd5,
        C_JAL = 4'd6,
        C_JR  = 4'd7,
        C_MD  = 4'd8
    } iclass_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;
    localparam logic [1:0] WD_LUI = 2'b11;

    localparam logic [1:0] AB_REG  = 2'b00;
    localparam logic [1:0] AB_SEXT = 2'b01;
    localparam logic [1:0] AB_ZEXT = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RA = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    localparam logic [1:0] PC_4   = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_REG = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decode into instruction class and datapath selects.
// mult/multu decode legally only when MC_CONTROL_MULDIV_EN is defined.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] fuc,
    output logic [3:0] cls,
    output logic [1:0] wd,
    output logic [1:0] alub,
    output logic [1:0] rdst,
    output logic [2:0] aluop,
    output logic [1:0] pcsel
);

    always_comb begin
        cls   = C_ILL;
        wd    = WD_ALU;
        alub  = AB_REG;
        rdst  = RD_RT;
        aluop = ALU_ADD;
        pcsel = PC_4;
        unique case (1'b1)
            (op == OP_R && fuc == F_ADDU): begin
                cls  = C_ALU;
                rdst = RD_RD;
            end
            (op == OP_R && fuc == F_SUBU): begin
                cls   = C_ALU;
                rdst  = RD_RD;
                aluop = ALU_SUB;
            end
            (op == OP_R && fuc == F_JR): begin
                cls   = C_JR;
                pcsel = PC_REG;
            end
`ifdef MC_CONTROL_MULDIV_EN
            (op == OP_R && (fuc == F_MULT || fuc == F_MULTU)): begin
                cls = C_MD;
            end
`endif
            (op == OP_ORI): begin
                cls   = C_ALU;
                alub  = AB_ZEXT;
                aluop = ALU_OR;
            end
            (op == OP_LUI): begin
                cls  = C_ALU;
                wd   = WD_LUI;
                alub = AB_ZEXT;
            end
            (op == OP_LW): begin
                cls  = C_LW;
                wd   = WD_MEM;
                alub = AB_SEXT;
            end
            (op == OP_SW): begin
                cls  = C_SW;
                alub = AB_SEXT;
            end
            (op == OP_BEQ): begin
                cls   = C_BEQ;
                aluop = ALU_SUB;
                pcsel = PC_BR;
            end
            (op == OP_J): begin
                cls   = C_J;
                pcsel = PC_JMP;
            end
            (op == OP_JAL): begin
                cls   = C_JAL;
                pcsel = PC_JMP;
                wd    = WD_PC4;
                rdst  = RD_RA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with strobes decoded from state and instruction class.
// Define MC_CONTROL_MULDIV_EN to enable mult/multu via the MD wait state.
module mc_control
    import mc_pkg::*;
#(
    parameter int MD_LATENCY = 5,
    parameter int STATE_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         fuc,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         WDctrl,
    output logic [1:0]         ALUctrl,
    output logic [1:0]         Regdst,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCctrl,
    output logic [STATE_W-1:0] state,
    output logic               instr_done,
    output logic               illegal,
    output logic               md_start
);

    state_t     st;
    iclass_t    cls;
    logic [3:0] cls_raw;
    logic [3:0] cnt;
    logic [1:0] dec_pc;

    mc_decode u_dec (
        .op    (op),
        .fuc   (fuc),
        .cls   (cls_raw),
        .wd    (WDctrl),
        .alub  (ALUctrl),
        .rdst  (Regdst),
        .aluop (ALUOp),
        .pcsel (dec_pc)
    );

    assign cls   = iclass_t'(cls_raw);
    assign state = STATE_W'(st);

    // IR still holds the previous instruction during fetch, so force PC+4 there
    assign PCctrl = (rst_n && st == S_IF) ? PC_4 : dec_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= S_IF;
            cnt <= '0;
        end else begin
            unique case (st)
                S_IF: if (mem_ready) st <= S_ID;
                S_ID: begin
                    case (cls)
                        C_ALU, C_LW, C_SW, C_BEQ, C_MD: st <= S_EX;
                        default: st <= S_IF;
                    endcase
                end
                S_EX: begin
                    case (cls)
                        C_ALU: st <= S_WB;
                        C_LW, C_SW: st <= S_MEM;
                        C_MD: begin
                            st  <= S_MD;
                            cnt <= 4'(MD_LATENCY);
                        end
                        default: st <= S_IF;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) st <= (cls == C_LW) ? S_WB : S_IF;
                end
                S_WB: st <= S_IF;
                S_MD: begin
                    if (cnt <= 4'd1) begin
                        st  <= S_IF;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: st <= S_IF;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            unique case (st)
                S_IF: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_ID: begin
                    case (cls)
                        C_J, C_JR: begin
                            PCWrite    = 1'b1;
                            instr_done = 1'b1;
                        end
                        C_JAL: begin
                            PCWrite    = 1'b1;
                            RegWrite   = 1'b1;
                            instr_done = 1'b1;
                        end
                        C_ILL: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EX: begin
                    if (cls == C_BEQ) begin
                        PCWrite    = zero;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    MemRead    = (cls == C_LW);
                    MemWrite   = (cls == C_SW);
                    instr_done = (cls == C_SW) && mem_ready;
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MD: instr_done = (cnt <= 4'd1);
                default: ;
            endcase
        end
    end

`ifdef MC_CONTROL_MULDIV_EN
    assign md_start = rst_n && (st == S_EX) && (cls == C_MD);
`else
    assign md_start = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control against a per-instruction model.
`timescale 1ns/1ps
module tb_mc_control;

    localparam int MDL = 5;
`ifdef MC_CONTROL_MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3;
    localparam int K_LW = 4, K_SW = 5, K_BEQ = 6, K_J = 7;
    localparam int K_JAL = 8, K_JR = 9, K_MULT = 10, K_MULTU = 11;
    localparam int K_BADOP = 12, K_BADFN = 13, NK = 14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, fuc;
    logic       zero, mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
    logic [1:0] WDctrl, ALUctrl, Regdst, PCctrl;
    logic [2:0] ALUOp;
    logic [2:0] state;
    logic       instr_done, illegal, md_start;

    mc_control #(.MD_LATENCY(MDL), .STATE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .fuc(fuc), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .WDctrl(WDctrl), .ALUctrl(ALUctrl), .Regdst(Regdst), .ALUOp(ALUOp),
        .PCctrl(PCctrl), .state(state), .instr_done(instr_done),
        .illegal(illegal), .md_start(md_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          len;
        logic [95:0] tr;
        int          regw;
        logic [1:0]  wd;
        logic [1:0]  rd;
        int          pcw;
        logic [7:0]  pct;
        int          mr;
        int          mw;
        int          irw;
        int          ill;
        int          mds;
        bit          chk_ex;
        logic [6:0]  ex;
    } exp_t;

    exp_t q[$];
    exp_t pe;
    int   sq[$];
    bit   rq[$];
    int   ntests = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: list the states the instruction visits, then derive every count from it
    function automatic void plan(int k, int ifw, int memw, bit z);
        bit legal, is_md;
        int nif, nmem;
        sq.delete();
        rq.delete();
        pe = '0;
        is_md = (k == K_MULT || k == K_MULTU);
        legal = !(k == K_BADOP || k == K_BADFN || (is_md && !MD_ON));
        repeat (ifw + 1) sq.push_back(0);
        sq.push_back(1);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                sq.push_back(2);
                sq.push_back(4);
            end
            K_LW: begin
                sq.push_back(2);
                repeat (memw + 1) sq.push_back(3);
                sq.push_back(4);
            end
            K_SW: begin
                sq.push_back(2);
                repeat (memw + 1) sq.push_back(3);
            end
            K_BEQ: sq.push_back(2);
            K_MULT, K_MULTU: if (legal) begin
                sq.push_back(2);
                repeat (MDL) sq.push_back(5);
            end
            default: ;
        endcase
        pe.len = sq.size();
        nif = 0;
        nmem = 0;
        foreach (sq[i]) begin
            pe.tr = {pe.tr[92:0], 3'(sq[i])};
            if (sq[i] == 0) begin
                rq.push_back(nif >= ifw);
                nif++;
            end else if (sq[i] == 3) begin
                rq.push_back(nmem >= memw);
                nmem++;
            end else begin
                rq.push_back(1'($urandom_range(0, 1)));
            end
        end
        pe.irw = 1;
        pe.ill = legal ? 0 : 1;
        pe.mds = (is_md && legal) ? 1 : 0;
        pe.mr = ifw + 1 + ((k == K_LW) ? memw + 1 : 0);
        pe.mw = (k == K_SW) ? memw + 1 : 0;
        pe.pcw = 1;
        pe.pct = {6'b0, 2'b00};
        case (k)
            K_J, K_JAL: begin pe.pcw = 2; pe.pct = {pe.pct[5:0], 2'b01}; end
            K_JR: begin pe.pcw = 2; pe.pct = {pe.pct[5:0], 2'b11}; end
            K_BEQ: if (z) begin pe.pcw = 2; pe.pct = {pe.pct[5:0], 2'b10}; end
            default: ;
        endcase
        case (k)
            K_ADDU, K_SUBU: begin pe.regw = 1; pe.wd = 2'b00; pe.rd = 2'b10; end
            K_ORI: begin pe.regw = 1; pe.wd = 2'b00; pe.rd = 2'b00; end
            K_LUI: begin pe.regw = 1; pe.wd = 2'b11; pe.rd = 2'b00; end
            K_LW: begin pe.regw = 1; pe.wd = 2'b01; pe.rd = 2'b00; end
            K_JAL: begin pe.regw = 1; pe.wd = 2'b10; pe.rd = 2'b01; end
            default: ;
        endcase
        pe.chk_ex = 1'b1;
        case (k)
            K_ADDU: pe.ex = {3'b000, 2'b00, 2'b00};
            K_SUBU: pe.ex = {3'b001, 2'b00, 2'b00};
            K_ORI: pe.ex = {3'b010, 2'b10, 2'b00};
            K_LW, K_SW: pe.ex = {3'b000, 2'b01, 2'b00};
            K_BEQ: pe.ex = {3'b001, 2'b00, 2'b10};
            default: pe.chk_ex = 1'b0;
        endcase
    endfunction

    task automatic enc(input int k, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (k)
            K_ADDU: begin o = 6'b000000; f = 6'b100001; end
            K_SUBU: begin o = 6'b000000; f = 6'b100011; end
            K_JR: begin o = 6'b000000; f = 6'b001000; end
            K_MULT: begin o = 6'b000000; f = 6'b011000; end
            K_MULTU: begin o = 6'b000000; f = 6'b011001; end
            K_ORI: o = 6'b001101;
            K_LUI: o = 6'b001111;
            K_LW: o = 6'b100011;
            K_SW: o = 6'b101011;
            K_BEQ: o = 6'b000100;
            K_J: o = 6'b000010;
            K_JAL: o = 6'b000011;
            K_BADOP: o = 6'b111111;
            default: begin
                o = 6'b000000;
                case ($urandom_range(0, 4))
                    0: f = 6'b100000;
                    1: f = 6'b100010;
                    2: f = 6'b100100;
                    3: f = 6'b000000;
                    default: f = 6'b111111;
                endcase
            end
        endcase
    endtask

    task automatic run_instr(input int k, input int ifw, input int memw, input bit z);
        logic [5:0] o, f;
        plan(k, ifw, memw, z);
        q.push_back(pe);
        enc(k, o, f);
        op = o;
        fuc = f;
        zero = z;
        foreach (rq[i]) begin
            mem_ready = rq[i];
            @(posedge clk);
            #1;
        end
    endtask

    int          a_cyc, a_regw, a_pcw, a_mr, a_mw, a_irw, a_ill, a_mds;
    logic [95:0] a_tr;
    logic [1:0]  a_wd, a_rd;
    logic [7:0]  a_pct;
    logic [6:0]  a_ex;

    function automatic void clr();
        a_cyc = 0; a_regw = 0; a_pcw = 0; a_mr = 0; a_mw = 0;
        a_irw = 0; a_ill = 0; a_mds = 0;
        a_tr = '0; a_wd = '0; a_rd = '0; a_pct = '0; a_ex = '0;
    endfunction

    initial begin
        exp_t e;
        clr();
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                clr();
            end else begin
                a_cyc++;
                a_tr = {a_tr[92:0], state};
                if (RegWrite) begin a_regw++; a_wd = WDctrl; a_rd = Regdst; end
                if (PCWrite) begin a_pcw++; a_pct = {a_pct[5:0], PCctrl}; end
                a_mr += int'(MemRead);
                a_mw += int'(MemWrite);
                a_irw += int'(IRWrite);
                a_ill += int'(illegal);
                a_mds += int'(md_start);
                if (state == 3'd2) a_ex = {ALUOp, ALUctrl, PCctrl};
                if ((MemRead || MemWrite) && !mem_ready)
                    chk("wait_no_write", {RegWrite, PCWrite}, 0);
                if (instr_done) begin
                    if (q.size() == 0) begin
                        ntests++;
                        nfail++;
                        $display("FAIL unexpected_done: got instr_done=1 with no instruction pending");
                    end else begin
                        e = q.pop_front();
                        chk("length", a_cyc, e.len);
                        chk("state_trace", a_tr, e.tr);
                        chk("regwrite_cnt", a_regw, e.regw);
                        if (e.regw != 0) begin
                            chk("wdctrl", a_wd, e.wd);
                            chk("regdst", a_rd, e.rd);
                        end
                        chk("pcwrite_cnt", a_pcw, e.pcw);
                        chk("pcctrl_trace", a_pct, e.pct);
                        chk("memread_cnt", a_mr, e.mr);
                        chk("memwrite_cnt", a_mw, e.mw);
                        chk("irwrite_cnt", a_irw, e.irw);
                        chk("illegal_cnt", a_ill, e.ill);
                        chk("md_start_cnt", a_mds, e.mds);
                        if (e.chk_ex) chk("ex_controls", a_ex, e.ex);
                    end
                    clr();
                end else if (a_cyc > 64) begin
                    ntests++;
                    nfail++;
                    $display("FAIL watchdog: no instr_done after %0d cycles", a_cyc);
                    clr();
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        op = 6'b000011;
        fuc = '0;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_strobes", {PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
                            instr_done, illegal, md_start}, 0);
        chk("rst_dec_regdst", Regdst, 2'b01);
        chk("rst_dec_wdctrl", WDctrl, 2'b10);
        chk("rst_dec_pcctrl", PCctrl, 2'b01);
        op = 6'b100011;
        #1;
        chk("rst_dec_aluctrl", ALUctrl, 2'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(K_ADDU, 0, 0, 0);
        run_instr(K_LW, 1, 3, 0);
        run_instr(K_BEQ, 0, 0, 0);
        run_instr(K_BEQ, 0, 0, 1);
        run_instr(K_JAL, 0, 0, 0);
        run_instr(K_BADOP, 0, 0, 0);
        run_instr(K_MULT, 0, 0, 0);
        run_instr(K_SW, 2, 2, 0);
        run_instr(K_JR, 0, 0, 0);
        run_instr(K_J, 1, 0, 0);
        run_instr(K_ORI, 0, 0, 1);
        run_instr(K_LUI, 0, 0, 0);
        run_instr(K_SUBU, 0, 0, 0);
        run_instr(K_MULTU, 0, 0, 0);
        run_instr(K_BADFN, 0, 0, 0);

        // sw stalled in MEM, then reset mid-instruction
        begin
            logic [5:0] o, f;
            plan(K_SW, 0, 8, 0);
            enc(K_SW, o, f);
            op = o;
            fuc = f;
            for (int i = 0; i < 5; i++) begin
                mem_ready = rq[i];
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b0;
            #1;
            chk("sw_hold_state", state, 3);
            chk("sw_hold_memwrite", MemWrite, 1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort_state", state, 0);
            chk("abort_memwrite", MemWrite, 0);
            chk("abort_strobes", {PCWrite, IRWrite, RegWrite, MemRead, instr_done}, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end

        for (int n = 0; n < 300; n++) begin
            int k, ifw, memw;
            k = $urandom_range(0, NK - 1);
            ifw = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : 0;
            memw = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : 0;
            run_instr(k, ifw, memw, 1'($urandom_range(0, 1)));
        end

        mem_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
